// File: rtl/fnd_scan_controller_if.sv
// Load-side bus of fnd_scan_controller: value to show, load strobe,
// per-digit decimal points and the busy flag returned by the converter.
interface fnd_scan_controller_if #(
  parameter int DIGITS = 4,
  parameter int DATA_W = 14
);
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic [DIGITS-1:0] dp_mask;
  logic              busy;

  // The producer drives the value and strobe, the controller answers busy.
  modport master (
    output data,
    output data_valid,
    output dp_mask,
    input  busy
  );

  // The controller side of the same bus.
  modport slave (
    input  data,
    input  data_valid,
    input  dp_mask,
    output busy
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: binary-to-BCD converter (sequential double dabble)
// feeding a time-multiplexed common-anode 7-segment bank of DIGITS positions.
// Optional feature macro: FND_LZB_EN enables leading-zero blanking.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active-low; commons are active-low.
module fnd_scan_controller #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1_000,
  parameter int DIGITS  = 4,
  parameter int DATA_W  = 14
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fnd_scan_controller_if.slave bus,
  output logic [7:0]           fnd_data,
  output logic [DIGITS-1:0]    fnd_com
);

  // Largest decimal value that fits on the bank, 10^n as a 64-bit constant.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam int DIV_TC  = CLK_HZ / SCAN_HZ - 1;
  localparam int DIV_W   = (DIV_TC > 0) ? $clog2(DIV_TC + 1) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // floor(0.3*DATA_W)+1 decimal digits always hold a DATA_W-bit value
  // for the supported widths; never fewer than the displayed digits.
  localparam int MIN_BCD = (DATA_W * 3) / 10 + 1;
  localparam int BCD_N   = (MIN_BCD > DIGITS) ? MIN_BCD : DIGITS;
  localparam int BCD_W   = 4 * BCD_N;
  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam logic [63:0] MAX_SHOWN = pow10(DIGITS) - 64'd1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [DATA_W-1:0] bin_reg;
  logic [BCD_W-1:0]  bcd_reg;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  count;
  logic              conv_ovf;

  logic [4*DIGITS-1:0] disp_bcd;
  logic                disp_ovf;
`ifdef FND_LZB_EN
  logic [DIGITS-1:0]   disp_blank;
  logic [DIGITS-1:0]   lzb_mask;
  logic                seen_nonzero;
`endif

  logic [DIV_W-1:0]  div_count;
  logic              tick;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [3:0]        nib_next;
  logic [7:0]        code_next;

  // Segment pattern for one decimal digit; unused nibble values stay dark.
  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    logic [7:0] c;
    case (nib)
      4'd0:    c = 8'hc0;
      4'd1:    c = 8'hf9;
      4'd2:    c = 8'ha4;
      4'd3:    c = 8'hb0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hf8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hff;
    endcase
    return c;
  endfunction

  assign bus.busy = (state != IDLE);

  // Converter state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Converter sequencing: load in IDLE, DATA_W shift cycles, one publish cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.data_valid) state_next = CONV;
      CONV:    if (count == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add 3 to every BCD nibble of 5 or more ahead of the next left shift.
  always_comb begin
    bcd_adj = bcd_reg;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd_reg[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
    end
  end

  // Double-dabble datapath: capture on load, then shift {bcd,bin} left once per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_reg  <= '0;
      bcd_reg  <= '0;
      count    <= '0;
      conv_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.data_valid) begin
            bin_reg  <= bus.data;
            bcd_reg  <= '0;
            count    <= CNT_W'(DATA_W);
            conv_ovf <= (64'(bus.data) > MAX_SHOWN);
          end
        end
        CONV: begin
          bcd_reg <= BCD_W'({bcd_adj, bin_reg[DATA_W-1]});
          bin_reg <= bin_reg << 1;
          count   <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FND_LZB_EN
  // Blank every digit above the most significant nonzero one; units always shown.
  always_comb begin
    lzb_mask     = '0;
    seen_nonzero = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (bcd_reg[4*i +: 4] != 4'd0) seen_nonzero = 1'b1;
      lzb_mask[i] = !seen_nonzero;
    end
  end
`endif

  // Display register is only written in DONE, so a half-converted value never shows.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_bcd   <= '0;
      disp_ovf   <= 1'b0;
`ifdef FND_LZB_EN
      disp_blank <= ~DIGITS'(1);
`endif
    end else if (state == DONE) begin
      disp_bcd   <= bcd_reg[4*DIGITS-1:0];
      disp_ovf   <= conv_ovf;
`ifdef FND_LZB_EN
      disp_blank <= lzb_mask;
`endif
    end
  end

  assign tick = (div_count == DIV_W'(DIV_TC));

  // Free-running scan divider producing a one-cycle tick at the terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  div_count <= '0;
    else if (tick) div_count <= '0;
    else           div_count <= div_count + 1'b1;
  end

  // Pattern for the digit the next tick will select.
  always_comb begin
    if (idx == IDX_W'(DIGITS - 1)) idx_next = '0;
    else                           idx_next = idx + 1'b1;
    nib_next = disp_bcd[4*idx_next +: 4];
    if (disp_ovf)                  code_next = 8'hbf;
`ifdef FND_LZB_EN
    else if (disp_blank[idx_next]) code_next = 8'hff;
`endif
    else                           code_next = seg_code(nib_next);
    if (bus.dp_mask[idx_next]) code_next[7] = 1'b0;
  end

  // Registered pin drivers, advanced only on scan ticks so nothing glitches between them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= IDX_W'(DIGITS - 1);
      fnd_com  <= '1;
      fnd_data <= 8'hff;
    end else if (tick) begin
      idx      <= idx_next;
      fnd_com  <= ~(DIGITS'(1) << idx_next);
      fnd_data <= code_next;
    end
  end

endmodule
